cla_multiword_seq: RTL and testbench

Sequencer that drives one shared 32-bit KPG carry-lookahead adder (`adder`) to perform wide additions of NWORDS×32 bits, one word per cycle.
- Carry is chained between words through the adder's 8-bit KPG-encoded carry-in (xin) and carry-out (xout).
- Sits between the Dadda final-stage producer and wide-result consumers.
- The adder is instantiated outside this block, in the parent; this block only drives and samples it.

---
 rtl/cla_kpg_pkg.sv | 28 ++
 rtl/cla_multiword_seq.sv | 110 +++++++++++
 tb/tb_cla_multiword_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cla_kpg_pkg.sv
// Shared definitions for the multi-word KPG carry-lookahead sequencer:
// carry encodings, sequencer state and a carry-byte decoder.
package cla_kpg_pkg;

  localparam logic [7:0] KPG_K = 8'h6B;
  localparam logic [7:0] KPG_G = 8'h67;
  localparam logic [7:0] KPG_P = 8'h70;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic carry;
    logic valid;
  } kpg_dec_t;

  // A resolved carry-out is only ever K or G; anything else (P included) is illegal.
  function automatic kpg_dec_t kpg_to_carry(input logic [7:0] x);
    kpg_dec_t d;
    d.carry = (x == KPG_G);
    d.valid = (x == KPG_G) || (x == KPG_K);
    return d;
  endfunction

endpackage

// File: rtl/cla_multiword_seq.sv
// Drives an external 32-bit KPG adder one word per cycle to build an
// NWORDS x 32-bit sum, chaining the carry through the adder's xin/xout bytes.
module cla_multiword_seq
  import cla_kpg_pkg::*;
#(
  parameter  int NWORDS = 2,
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NWORDS-1:0]   in_a,
  input  logic [32*NWORDS-1:0]   in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NWORDS-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_err,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic [7:0]             add_xin,
  input  logic [31:0]            add_si,
  input  logic [7:0]             add_xout
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  seq_state_t                 state;
  logic [IDX_W-1:0]           idx;
  logic                       carry;
  logic [NWORDS-1:0][31:0]    a_reg;
  logic [NWORDS-1:0][31:0]    b_reg;
  logic [NWORDS-1:0][31:0]    sum_reg;

  kpg_dec_t                   dec;
  logic                       new_carry;

  assign out_sum = sum_reg;

  // An illegal carry-out is flagged and treated as no carry so the chain stays defined.
  assign dec       = kpg_to_carry(add_xout);
  assign new_carry = dec.valid ? dec.carry : 1'b0;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_xin = KPG_K;
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_xin = carry ? KPG_G : KPG_K;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      out_cout  <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            out_err  <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_si;
          carry        <= new_carry;
          if (!dec.valid) out_err <= 1'b1;
          if (idx == LAST) begin
            out_cout  <= new_carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Bench for cla_multiword_seq: behavioural 32-bit KPG adder with fault
// injection, directed vector table, corner sequences and random operands.
module tb_cla_multiword_seq;
  import cla_kpg_pkg::*;

  localparam int NWORDS = 2;
  localparam int W      = 32 * NWORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_cin;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          out_valid, out_ready, out_cout, out_err;
  logic [31:0]   add_a, add_b, add_si;
  logic [7:0]    add_xin, add_xout;
  logic          inj_xout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] xin_log [8];

  always #5 clk = ~clk;

  cla_multiword_seq #(.NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
    .add_a(add_a), .add_b(add_b), .add_xin(add_xin),
    .add_si(add_si), .add_xout(add_xout)
  );

  // Adder model: plain 33-bit arithmetic, carry-out encoded as K/G (or forced P).
  logic [32:0] add_full;
  always_comb begin
    add_full = {1'b0, add_a} + {1'b0, add_b} + {32'd0, (add_xin == KPG_G)};
    add_si   = add_full[31:0];
    add_xout = inj_xout ? KPG_P : (add_full[32] ? KPG_G : KPG_K);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic inj, input int hold,
                        input logic [W-1:0] es, input logic ec, input logic ee);
    int w, lat;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk({nm, " in_ready"}, 128'(in_ready), 128'(1));
    in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inj_xout = inj;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (lat < 8) xin_log[lat] = add_xin;
      @(posedge clk); #1;
      inj_xout = 1'b0;
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(NWORDS));
    chk({nm, " sum"}, 128'(out_sum), 128'(es));
    chk({nm, " cout/err/ready"}, {125'd0, out_cout, out_err, in_ready}, {125'd0, ec, ee, 1'b0});
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk({nm, " hold"}, {out_valid, in_ready, out_cout, 61'd0, out_sum},
          {1'b1, 1'b0, ec, 61'd0, es});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " release"}, {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    int           hold;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   ref_full;
    logic [W-1:0] bq_a [3], bq_b [3];
    logic         bq_c [3];
    int           acc_cyc [3];
    int           c, nacc, nres;

    tbl[0] = '{64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0, 64'h00000001_00000000, 1'b0};
    tbl[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 0, 64'h0, 1'b1};
    tbl[2] = '{64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b0, 5, 64'h23456789_ABCDF001, 1'b0};
    tbl[3] = '{64'h80000000_00000000, 64'h80000000_00000000, 1'b1, 1, 64'h00000000_00000001, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0; inj_xout = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset flags", {123'd0, in_ready, out_valid, out_cout, out_err, 1'b0},
        {123'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset sum", 128'(out_sum), 128'(0));
    chk("idle adder drive", {56'd0, add_a, add_b, add_xin}, {56'd0, 32'd0, 32'd0, KPG_K});

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, tbl[i].hold,
             tbl[i].sum, tbl[i].cout, 1'b0);
      if (i == 0) begin
        chk("vec0 xin word0", 128'(xin_log[0]), 128'(KPG_K));
        chk("vec0 xin word1", 128'(xin_log[1]), 128'(KPG_G));
      end
    end

    // Illegal P on word 0: flagged, treated as no carry; next clean op clears the flag.
    run_op("inject P", 64'hFFFFFFFF_00000005, 64'h00000000_00000007, 1'b0, 1'b1, 0,
           64'hFFFFFFFF_0000000C, 1'b0, 1'b1);
    run_op("after inject", 64'h1, 64'h2, 1'b0, 1'b0, 0, 64'h3, 1'b0, 1'b0);

    // Reset in the second RUN cycle abandons the operation.
    in_a = 64'hAAAA_AAAA_5555_5555; in_b = 64'h1111_1111_1111_1111; in_cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid-op reset", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
    chk("mid-op reset sum", 128'(out_sum), 128'(0));
    repeat (3) @(posedge clk); #1;
    chk("mid-op reset quiet", 128'(out_valid), 128'(0));
    run_op("post reset", 64'hDEADBEEF_CAFEF00D, 64'h21524110_35010FF3, 1'b0, 1'b0, 0,
           64'h00000000_00000000, 1'b1, 1'b0);

    // Random operands against plain wide arithmetic.
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, int'($urandom_range(0, 2)),
             ref_full[W-1:0], ref_full[W], 1'b0);
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      bq_a[i] = {$urandom, $urandom};
      bq_b[i] = {$urandom, $urandom};
      bq_c[i] = 1'($urandom_range(0, 1));
    end
    c = 0; nacc = 0; nres = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = bq_a[0]; in_b = bq_b[0]; in_cin = bq_c[0];
    while (nres < 3 && c < 60) begin
      if (out_valid) begin
        ref_full = {1'b0, bq_a[nres]} + {1'b0, bq_b[nres]} + {{W{1'b0}}, bq_c[nres]};
        chk($sformatf("b2b%0d result", nres), {63'd0, out_cout, out_sum}, {63'd0, ref_full});
        nres++;
      end
      if (in_ready && nacc < 3) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk); #1;
      c++;
      if (nacc < 3) begin
        in_a = bq_a[nacc]; in_b = bq_b[nacc]; in_cin = bq_c[nacc];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b results seen", 128'(nres), 128'(3));
    if (nacc == 3) begin
      chk("b2b spacing 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NWORDS + 2));
      chk("b2b spacing 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'(NWORDS + 2));
    end else begin
      chk("b2b accepts", 128'(nacc), 128'(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
